// File: rtl/booth_product_accumulator.sv
// Saturating multiply-accumulate back end for the Radix-4 Booth multiplier.
// Sums signed product beats per first/last-delimited group and emits one registered result.
module booth_product_accumulator #(
  parameter int unsigned N     = 32,
  parameter int unsigned ACC_W = 72,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*N:0]       product,
  input  logic               first,
  input  logic               last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ACC_W-1:0]   acc_out,
  output logic               ovf_out,
  output logic [CNT_W-1:0]   beats_out
);

  localparam int unsigned PW = 2 * N + 1;

  typedef enum logic [0:0] {StAccum, StDone} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] res_acc_q, res_acc_d;
  logic             res_ovf_q, res_ovf_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic             beat;
  logic [ACC_W-1:0] p, base, sum;
  logic [ACC_W:0]   sum_wide;
  logic             sat, ovf_next;
  logic [CNT_W-1:0] cnt_base, cnt_next;

  assign p         = {{(ACC_W - PW){product[PW-1]}}, product};
  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StDone);
  assign beat      = in_valid && in_ready;

  // A first-tagged beat starts from zero regardless of leftover partial state.
  always_comb begin
    base     = first ? '0 : acc_q;
    sum_wide = {base[ACC_W-1], base} + {p[ACC_W-1], p};
    sat      = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
    if (sat) begin
      sum = {sum_wide[ACC_W], {(ACC_W - 1){~sum_wide[ACC_W]}}};
    end else begin
      sum = sum_wide[ACC_W-1:0];
    end
    ovf_next = (first ? 1'b0 : ovf_q) | sat;
    cnt_base = first ? '0 : cnt_q;
    cnt_next = (&cnt_base) ? cnt_base : cnt_base + CNT_W'(1);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    cnt_d     = cnt_q;
    res_acc_d = res_acc_q;
    res_ovf_d = res_ovf_q;
    res_cnt_d = res_cnt_q;
    unique case (state_q)
      StAccum: begin
        if (beat) begin
          if (last) begin
            res_acc_d = sum;
            res_ovf_d = ovf_next;
            res_cnt_d = cnt_next;
            acc_d     = '0;
            ovf_d     = 1'b0;
            cnt_d     = '0;
            state_d   = StDone;
          end else begin
            acc_d = sum;
            ovf_d = ovf_next;
            cnt_d = cnt_next;
          end
        end
      end
      StDone: begin
        if (out_ready) state_d = StAccum;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StAccum;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      cnt_q     <= '0;
      res_acc_q <= '0;
      res_ovf_q <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      cnt_q     <= cnt_d;
      res_acc_q <= res_acc_d;
      res_ovf_q <= res_ovf_d;
      res_cnt_q <= res_cnt_d;
    end
  end

  assign acc_out   = res_acc_q;
  assign ovf_out   = res_ovf_q;
  assign beats_out = res_cnt_q;

endmodule
